// File: rtl/CPU_pkg.sv
// Shared CPU types: address/data word typedefs and the default store-buffer depth.
package CPU_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [15:0] word_t;

  localparam int STORE_BUFFER_DEPTH = 4;

endpackage : CPU_pkg

// File: rtl/store_buffer_if.sv
// Push / drain / load-forward handshake bundle between writeback, memory and the store buffer.
interface store_buffer_if
  import CPU_pkg::*;
#(
  parameter int ADDR_WIDTH = $bits(addr_t),
  parameter int DATA_WIDTH = $bits(word_t)
);

  logic                  push_valid;
  logic                  push_ready;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [DATA_WIDTH-1:0] push_data;

  logic                  drain_valid;
  logic                  drain_ready;
  logic [ADDR_WIDTH-1:0] drain_addr;
  logic [DATA_WIDTH-1:0] drain_data;

  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  modport master (
    output push_valid, push_addr, push_data, drain_ready, ld_valid, ld_addr,
    input  push_ready, drain_valid, drain_addr, drain_data, fwd_hit, fwd_data
  );

  modport slave (
    input  push_valid, push_addr, push_data, drain_ready, ld_valid, ld_addr,
    output push_ready, drain_valid, drain_addr, drain_data, fwd_hit, fwd_data
  );

endinterface : store_buffer_if

// File: rtl/MOD_find_first_match.sv
// Returns the index of the first valid entry equal to target; REVERSE=1 searches from the top index down.
module MOD_find_first_match #(
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 16,
  parameter bit REVERSE    = 1'b0
) (
  input  logic [DATA_WIDTH-1:0]   data_i [SIZE],
  input  logic                    valid_i[SIZE],
  input  logic [DATA_WIDTH-1:0]   target_i,
  output logic                    found_o,
  output logic [$clog2(SIZE)-1:0] idx_o
);

  localparam int IW = $clog2(SIZE);

  // NOTE: outputs get defaults before the loop so no path leaves them unassigned (no latch).
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    // Scan so that the preferred end is visited last and overwrites earlier hits.
    for (int k = 0; k < SIZE; k++) begin
      if (valid_i[REVERSE ? k : SIZE-1-k] && data_i[REVERSE ? k : SIZE-1-k] == target_i) begin
        found_o = 1'b1;
        idx_o   = IW'(REVERSE ? k : SIZE-1-k);
      end
    end
  end

endmodule : MOD_find_first_match

// File: rtl/store_buffer.sv
// Circular FIFO of retired stores awaiting memory write, with youngest-match store-to-load forwarding.
module store_buffer
  import CPU_pkg::*;
#(
  parameter int DEPTH      = STORE_BUFFER_DEPTH,
  parameter int ADDR_WIDTH = $bits(addr_t),
  parameter int DATA_WIDTH = $bits(word_t)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  store_buffer_if.slave              sb,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH], addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH], data_d [DEPTH];
  logic                  valid_q[DEPTH], valid_d[DEPTH];
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  logic push_fire, pop_fire;

  // Status and drain side come straight from registers.
  assign full            = (count_q == CW'(DEPTH));
  assign empty           = (count_q == '0);
  assign count           = count_q;
  assign sb.push_ready   = !full;
  assign sb.drain_valid  = !empty;
  assign sb.drain_addr   = addr_q[head_q];
  assign sb.drain_data   = data_q[head_q];

  assign push_fire = sb.push_valid && !full;
  assign pop_fire  = !empty && sb.drain_ready;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) valid_d[i] = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_fire) begin
        addr_d[tail_q]  = sb.push_addr;
        data_d[tail_q]  = sb.push_data;
        valid_d[tail_q] = 1'b1;
        tail_d          = tail_q + PW'(1);
      end
      if (pop_fire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PW'(1);
      end
      count_d = count_q + CW'(push_fire) - CW'(pop_fire);
    end
  end

  // NOTE: the entry arrays are reset too, so drain outputs read 0 rather than X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Oldest entry at index 0, youngest at the top, so a reverse search picks the youngest match.
  logic [ADDR_WIDTH-1:0] aged_addr [DEPTH];
  logic                  aged_valid[DEPTH];
  logic                  match_found;
  logic [PW-1:0]         match_idx;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      aged_addr[i]  = addr_q[head_q + PW'(i)];
      aged_valid[i] = valid_q[head_q + PW'(i)];
    end
  end

  MOD_find_first_match #(
    .SIZE       (DEPTH),
    .DATA_WIDTH (ADDR_WIDTH),
    .REVERSE    (1'b1)
  ) u_find (
    .data_i   (aged_addr),
    .valid_i  (aged_valid),
    .target_i (sb.ld_addr),
    .found_o  (match_found),
    .idx_o    (match_idx)
  );

  assign sb.fwd_hit  = match_found && sb.ld_valid;
  assign sb.fwd_data = sb.fwd_hit ? data_q[head_q + match_idx] : '0;

endmodule : store_buffer

// File: tb/tb_store_buffer.sv
// Directed-vector bench for store_buffer: fill/full, wrap-around forwarding, push+pop, flush and async reset.
module tb_store_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [2:0] count;
  logic       full, empty;

  int n_checks = 0;
  int n_fail   = 0;

  store_buffer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) sb_if ();

  store_buffer #(.DEPTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if),
    .flush (flush),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] d);
    sb_if.push_valid = 1'b1;
    sb_if.push_addr  = a;
    sb_if.push_data  = d;
    cyc();
    sb_if.push_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [15:0] a, input logic hit, input logic [15:0] d);
    sb_if.ld_addr = a;
    #1;
    check({tag, "_hit"}, 32'(sb_if.fwd_hit), 32'(hit));
    check({tag, "_data"}, 32'(sb_if.fwd_data), 32'(d));
  endtask

  initial begin
    rst_n             = 1'b0;
    flush             = 1'b0;
    sb_if.push_valid  = 1'b0;
    sb_if.push_addr   = '0;
    sb_if.push_data   = '0;
    sb_if.drain_ready = 1'b0;
    sb_if.ld_valid    = 1'b1;
    sb_if.ld_addr     = '0;
    #2;
    check("rst_push_ready", 32'(sb_if.push_ready), 32'd1);
    check("rst_drain_valid", 32'(sb_if.drain_valid), 32'd0);
    check("rst_drain_addr", 32'(sb_if.drain_addr), 32'h0);
    check("rst_drain_data", 32'(sb_if.drain_data), 32'h0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    lookup("rst_ld0", 16'h0000, 1'b0, 16'h0000);
    rst_n = 1'b1;
    cyc();
    check("idle_empty", 32'(empty), 32'd1);
    lookup("idle_ld0", 16'h0000, 1'b0, 16'h0000);

    // Fill to full with drain stalled.
    push(16'h0010, 16'h1111);
    check("lat_drain_valid", 32'(sb_if.drain_valid), 32'd1);
    push(16'h0020, 16'h2222);
    push(16'h0030, 16'h3333);
    push(16'h0040, 16'h4444);
    check("full_flag", 32'(full), 32'd1);
    check("full_count", 32'(count), 32'd4);
    check("full_push_ready", 32'(sb_if.push_ready), 32'd0);
    push(16'h0050, 16'h5555);
    check("fifth_count", 32'(count), 32'd4);
    check("full_drain_addr", 32'(sb_if.drain_addr), 32'h0010);
    check("full_drain_data", 32'(sb_if.drain_data), 32'h1111);
    lookup("fifth_ld", 16'h0050, 1'b0, 16'h0000);
    lookup("full_ld30", 16'h0030, 1'b1, 16'h3333);

    // Drain all four in order.
    sb_if.drain_ready = 1'b1;
    check("drain0", 32'(sb_if.drain_addr), 32'h0010); cyc();
    check("drain1", 32'(sb_if.drain_addr), 32'h0020); cyc();
    check("drain2", 32'(sb_if.drain_addr), 32'h0030); cyc();
    check("drain3", 32'(sb_if.drain_addr), 32'h0040); cyc();
    sb_if.drain_ready = 1'b0;
    check("drained_empty", 32'(empty), 32'd1);
    check("drained_drain_valid", 32'(sb_if.drain_valid), 32'd0);

    // Youngest match wins across tail wrap.
    push(16'h00AA, 16'h0001);
    push(16'h00BB, 16'h0002);
    sb_if.drain_ready = 1'b1;
    cyc(); cyc();
    sb_if.drain_ready = 1'b0;
    check("wrap_pre_empty", 32'(empty), 32'd1);
    lookup("wrap_stale_aa", 16'h00AA, 1'b0, 16'h0000);
    push(16'h00AA, 16'h0003);
    push(16'h00CC, 16'h0004);
    push(16'h00AA, 16'h0005);
    push(16'h00DD, 16'h0006);
    check("wrap_full", 32'(full), 32'd1);
    lookup("wrap_aa", 16'h00AA, 1'b1, 16'h0005);
    lookup("wrap_cc", 16'h00CC, 1'b1, 16'h0004);
    sb_if.drain_ready = 1'b1;
    cyc();
    sb_if.drain_ready = 1'b0;
    check("wrap_pop_count", 32'(count), 32'd3);
    lookup("wrap_aa_after", 16'h00AA, 1'b1, 16'h0005);

    // Simultaneous push and pop at count 2.
    sb_if.drain_ready = 1'b1;
    cyc();
    check("pp_start_count", 32'(count), 32'd2);
    check("pp_head0", 32'(sb_if.drain_addr), 32'h00AA);
    push(16'h00EE, 16'h0007);
    check("pp_count1", 32'(count), 32'd2);
    check("pp_head1", 32'(sb_if.drain_addr), 32'h00DD);
    push(16'h00FF, 16'h0008);
    check("pp_count2", 32'(count), 32'd2);
    check("pp_head2", 32'(sb_if.drain_addr), 32'h00EE);
    check("pp_head2_data", 32'(sb_if.drain_data), 32'h0007);
    cyc();
    check("pp_head3", 32'(sb_if.drain_addr), 32'h00FF);
    cyc();
    sb_if.drain_ready = 1'b0;
    check("pp_empty", 32'(empty), 32'd1);

    // Entry popped this cycle still forwards; gone on the next cycle.
    push(16'h0050, 16'h9999);
    sb_if.drain_ready = 1'b1;
    lookup("popfwd_same", 16'h0050, 1'b1, 16'h9999);
    sb_if.ld_valid = 1'b0;
    lookup("popfwd_ldinv", 16'h0050, 1'b0, 16'h0000);
    sb_if.ld_valid = 1'b1;
    cyc();
    sb_if.drain_ready = 1'b0;
    lookup("popfwd_next", 16'h0050, 1'b0, 16'h0000);

    // Flush beats a concurrent push and pop.
    push(16'h0011, 16'h000A);
    push(16'h0022, 16'h000B);
    push(16'h0033, 16'h000C);
    check("flush_pre_count", 32'(count), 32'd3);
    flush             = 1'b1;
    sb_if.push_valid  = 1'b1;
    sb_if.push_addr   = 16'h0044;
    sb_if.push_data   = 16'h000D;
    sb_if.drain_ready = 1'b1;
    cyc();
    flush             = 1'b0;
    sb_if.push_valid  = 1'b0;
    sb_if.drain_ready = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    lookup("flush_ld11", 16'h0011, 1'b0, 16'h0000);
    lookup("flush_ld44", 16'h0044, 1'b0, 16'h0000);

    // Asynchronous reset between edges.
    push(16'h0077, 16'h000E);
    check("arst_pre_count", 32'(count), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_drain_valid", 32'(sb_if.drain_valid), 32'd0);
    check("arst_drain_addr", 32'(sb_if.drain_addr), 32'h0);
    check("arst_drain_data", 32'(sb_if.drain_data), 32'h0);
    check("arst_push_ready", 32'(sb_if.push_ready), 32'd1);
    lookup("arst_ld77", 16'h0077, 1'b0, 16'h0000);
    rst_n = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_store_buffer

// File: doc/store_buffer.md
# store_buffer

Circular FIFO of retired stores waiting to be written to data memory, with same-cycle store-to-load forwarding. It sits between the writeback stage (push side) and the data-memory write port (drain side). For load lookup it presents its entries in age order to an internal `MOD_find_first_match` instance (REVERSE=1), so the youngest matching store wins.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `ADDR_WIDTH`, 16: store/load word address width.
- `DATA_WIDTH`, 16: store data width. Word granularity only; no byte masks.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `push_valid` in 1: store offered by writeback.
- `push_addr` in ADDR_WIDTH: store address.
- `push_data` in DATA_WIDTH: store data.
- `push_ready` out 1: equals `!full`.
- `drain_valid` out 1: equals `!empty`; head entry offered to memory.
- `drain_addr` out ADDR_WIDTH: head entry address.
- `drain_data` out DATA_WIDTH: head entry data.
- `drain_ready` in 1: memory accepts head this cycle.
- `ld_addr` in ADDR_WIDTH: load address for forwarding lookup.
- `ld_valid` in 1: lookup enable; qualifies `fwd_hit`.
- `fwd_hit` out 1: a valid entry matches `ld_addr`.
- `fwd_data` out DATA_WIDTH: data of youngest matching entry; 0 when `!fwd_hit`.
- `flush` in 1: synchronous clear of all entries.
- `count` out $clog2(DEPTH+1): occupied entries.
- `full` out 1, `empty` out 1: status flags.

## Operation
- State: arrays `addr_q[DEPTH]`, `data_q[DEPTH]`, `valid_q[DEPTH]`; `head_q`, `tail_q` ($clog2(DEPTH) bits, wrap modulo DEPTH); `count_q`.
- Push fires on `push_valid && push_ready`: write the tail slot, set its valid bit, tail+1.
- Pop fires on `drain_valid && drain_ready`: clear valid at head, head+1. Slot contents are not cleared.
- Push and pop in the same cycle: both happen; count unchanged.
- Full: `push_ready`=0 even when a pop fires the same cycle. There is no full-bypass.
- Empty: `drain_valid`=0. Drain outputs still show `addr_q/data_q[head_q]`, so they are stale but stable.
- Flush has priority over push and pop in the same cycle. Next cycle: all valid bits 0, head=tail=0, count=0.
- Forwarding is purely combinational.
  - Build age-ordered views: `aged_addr[i] = addr_q[(head_q+i) mod DEPTH]`, with the same rotation for `valid_q`.
  - Feed these to `MOD_find_first_match` (SIZE=DEPTH, DATA_WIDTH=ADDR_WIDTH, REVERSE=1, target=`ld_addr`).
  - `fwd_hit` = `found && ld_valid`.
  - `fwd_data` = `data_q[(head_q+idx) mod DEPTH]`.
- An entry being pushed this cycle is not visible to lookup. An entry being popped this cycle is still visible.
- `ld_valid` has no effect on state.

## Timing
- Reset values: head=tail=count=0, all valid=0, all addr/data=0.
- Outputs under reset: `push_ready`=1, `drain_valid`=0, `drain_addr`=`drain_data`=0, `fwd_hit`=0, `fwd_data`=0, `full`=0, `empty`=1, `count`=0.
- Reset asserted mid-operation discards all pending stores immediately, independent of `clk`.
- Push-to-drain latency: 1 cycle (push at edge N gives `drain_valid` in cycle N+1 if the buffer was empty).
- Push-to-forward latency: 1 cycle.
- Lookup latency: 0 cycles (combinational from `ld_addr`, `ld_valid` and registered state).
- `full`, `empty`, `count`, `push_ready`, `drain_valid` and the drain outputs are derived from registers only; no combinational path from any input.

## Structure
- Shared package `CPU_pkg`: `addr_t` and `word_t` typedefs, plus default `STORE_BUFFER_DEPTH`.
- Sub-module: one `MOD_find_first_match` instance, used unchanged.
- Rotation, pointer and counter logic stay local to this block.

## Test plan
- Reset, then idle: `empty`=1, `push_ready`=1, `drain_valid`=0, `count`=0. Lookup `ld_addr`=0x0000 with `ld_valid`=1 → `fwd_hit`=0.
- Fill to full: push 0x0010/0x1111, 0x0020/0x2222, 0x0030/0x3333, 0x0040/0x4444 with `drain_ready`=0.
  - Required: `full`=1, `count`=4, `push_ready`=0.
  - A fifth push is ignored.
  - `drain_addr`=0x0010.
- Youngest wins across wrap-around:
  - Push 0x00AA/0x0001 and 0x00BB/0x0002, drain both.
  - Push 0x00AA/0x0003, 0x00CC/0x0004, 0x00AA/0x0005, 0x00DD/0x0006 (tail wraps).
  - Lookup 0x00AA → `fwd_hit`=1, `fwd_data`=0x0005.
  - After popping one entry → still 0x0005.
- Simultaneous push and pop at `count`=2: `count` stays 2; drain order matches push order.
- Same cycle pop of 0x0050/0x9999 (only entry) plus lookup of 0x0050 → `fwd_hit`=1, `fwd_data`=0x9999. Next cycle `fwd_hit`=0.
- `flush` together with `push_valid` and `drain_ready` at `count`=3 → next cycle `count`=0, `empty`=1, no lookup hits. Separately, `rst_n` asserted low between clock edges → outputs go to reset values immediately.
